// File: rtl/bat_vga_gauge.sv
// Battery gauge renderer: 640x480@60 VGA timing plus a battery icon whose fill
// and colour follow the CPU's battery-control word, with an optional charging blink.
module bat_vga_gauge #(
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] bat_ctl,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       video_on,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int VW = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_L = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_L = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

  // Icon geometry: body outline, inner cavity, terminal nub.
  localparam logic [HW-1:0] OX0 = HW'(240);
  localparam logic [HW-1:0] OX1 = HW'(399);
  localparam logic [HW-1:0] IX0 = HW'(244);
  localparam logic [HW-1:0] IX1 = HW'(395);
  localparam logic [HW-1:0] NX0 = HW'(400);
  localparam logic [HW-1:0] NX1 = HW'(411);
  localparam logic [VW-1:0] OY0 = VW'(200);
  localparam logic [VW-1:0] OY1 = VW'(279);
  localparam logic [VW-1:0] IY0 = VW'(204);
  localparam logic [VW-1:0] IY1 = VW'(275);
  localparam logic [VW-1:0] NY0 = VW'(224);
  localparam logic [VW-1:0] NY1 = VW'(255);

  function automatic logic [3:0] sat_level(input logic [3:0] lvl);
    return (lvl > 4'd10) ? 4'd10 : lvl;
  endfunction

  function automatic logic [11:0] fill_colour(input logic [3:0] lvl, input logic blue_now);
    if (blue_now)        return 12'h00F;
    else if (lvl <= 4'd2) return 12'hF00;
    else if (lvl <= 4'd5) return 12'hFF0;
    else                 return 12'h0F0;
  endfunction

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [4:0]    bat_sync_p0, bat_sync_p1;
  logic [3:0]    lvl_q;
  logic          chg_q;
  logic [FW-1:0] frame_cnt;
  logic          blink_ph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // ---- stage p0: decode of the current counter position ----
  logic          visible_p0, hsync_p0, vsync_p0, vblank_start_p0;
  logic          in_outer, in_inner, in_nub, in_fill;
  logic [3:0]    lvl_eff;
  logic [7:0]    fill_w;
  logic [HW-1:0] x_off;
  logic [11:0]   rgb_p0;

  always_comb begin
    visible_p0      = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);
    hsync_p0        = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
    vsync_p0        = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
    vblank_start_p0 = (h_cnt == '0) && (v_cnt == V_VIS_L);

    in_outer = (h_cnt >= OX0) && (h_cnt <= OX1) && (v_cnt >= OY0) && (v_cnt <= OY1);
    in_inner = (h_cnt >= IX0) && (h_cnt <= IX1) && (v_cnt >= IY0) && (v_cnt <= IY1);
    in_nub   = (h_cnt >= NX0) && (h_cnt <= NX1) && (v_cnt >= NY0) && (v_cnt <= NY1);

    // Fill is 15 px per level step starting at the cavity's left edge.
    lvl_eff = sat_level(lvl_q);
    fill_w  = {lvl_eff, 4'b0000} - {4'b0000, lvl_eff};
    x_off   = h_cnt - IX0;
    in_fill = (h_cnt >= IX0) && (x_off < HW'(fill_w)) && (v_cnt >= IY0) && (v_cnt <= IY1);

    rgb_p0 = 12'h000;
    if (!visible_p0)              rgb_p0 = 12'h000;
    else if (in_outer && !in_inner) rgb_p0 = 12'hFFF;
    else if (in_nub)              rgb_p0 = 12'hFFF;
    else if (in_fill)             rgb_p0 = fill_colour(lvl_eff, chg_q && blink_ph);
  end

  // ---- stage p1: registered outputs, mutually aligned ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync              <= 1'b1;
      vsync              <= 1'b1;
      {red, green, blue} <= 12'h000;
      video_on           <= 1'b0;
      frame_tick         <= 1'b0;
    end else begin
      hsync              <= hsync_p0;
      vsync              <= vsync_p0;
      {red, green, blue} <= rgb_p0;
      video_on           <= visible_p0;
      frame_tick         <= vblank_start_p0;
    end
  end

  // Level and charge only update at the start of vertical blank to avoid tearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bat_sync_p0 <= '0;
      bat_sync_p1 <= '0;
      lvl_q       <= '0;
      chg_q       <= 1'b0;
      frame_cnt   <= '0;
      blink_ph    <= 1'b0;
    end else begin
      bat_sync_p0 <= bat_ctl;
      bat_sync_p1 <= bat_sync_p0;
      if (vblank_start_p0) begin
        lvl_q <= bat_sync_p1[3:0];
        chg_q <= bat_sync_p1[4];
      end
      if (!chg_q) begin
        frame_cnt <= '0;
        blink_ph  <= 1'b0;
      end else if (vblank_start_p0) begin
        if (frame_cnt == F_LAST) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bat_vga_gauge.sv
// Bench for bat_vga_gauge using a compact raster (icon area kept) and a short blink period.
module tb_bat_vga_gauge;

  localparam int H_VIS = 412, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 230, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int BF = 2;
  localparam int H_T = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_T = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_T * V_T;
  localparam int TICK_POS = V_VIS * H_T;
  localparam int ROW = 226;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] bat_ctl = 5'h00;
  logic       hsync, vsync, video_on, frame_tick;
  logic [3:0] red, green, blue;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_lvl = 0;
  bit m_chg = 1'b0;
  int m_n = 0;

  always #5 clk = ~clk;

  bat_vga_gauge #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .bat_ctl(bat_ctl),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .video_on(video_on), .frame_tick(frame_tick)
  );

  function automatic logic [11:0] exp_rgb(int x, int y);
    int le;
    if (x >= H_VIS || y >= V_VIS) return 12'h000;
    if (x >= 240 && x <= 399 && y >= 200 && y <= 279 &&
        !(x >= 244 && x <= 395 && y >= 204 && y <= 275)) return 12'hFFF;
    if (x >= 400 && x <= 411 && y >= 224 && y <= 255) return 12'hFFF;
    le = (m_lvl > 10) ? 10 : m_lvl;
    if (x >= 244 && x < 244 + 15 * le && y >= 204 && y <= 275) begin
      if (m_chg && ((m_n / BF) % 2 == 1)) return 12'h00F;
      if (le <= 2) return 12'hF00;
      if (le <= 5) return 12'hFF0;
      return 12'h0F0;
    end
    return 12'h000;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards the outputs show the decode of raster position cyc-1.
  task automatic step();
    int pos;
    @(posedge clk);
    #1;
    cyc++;
    pos = (cyc - 1) % FRAME;
    if (pos == TICK_POS) begin
      if (m_chg && bat_ctl[4]) m_n++;
      else m_n = 0;
      m_lvl = int'(bat_ctl[3:0]);
      m_chg = bat_ctl[4];
    end
  endtask

  task automatic goto(int x, int y);
    int cur, d;
    cur = (cyc == 0) ? -1 : (cyc - 1) % FRAME;
    d = ((y * H_T + x - cur) % FRAME + FRAME) % FRAME;
    repeat (d) step();
  endtask

  task automatic goto_tick();
    goto(H_T - 1, V_VIS - 1);
    check("tick_before", 32'(frame_tick), 32'd0);
    step();
    check("tick_pulse", 32'(frame_tick), 32'd1);
    step();
    check("tick_after", 32'(frame_tick), 32'd0);
  endtask

  task automatic pixel(string tag, int x, int y, logic [11:0] exp);
    goto(x, y);
    check(tag, 32'({red, green, blue}), 32'(exp));
  endtask

  task automatic scan_row(string tag, int y);
    int e_rgb, e_vo, e_hs, e_vs, fx;
    logic [11:0] fo, fe;
    e_rgb = 0; e_vo = 0; e_hs = 0; e_vs = 0; fx = -1; fo = '0; fe = '0;
    goto(0, y);
    for (int x = 0; x < H_T; x++) begin
      if (x > 0) step();
      if ({red, green, blue} !== exp_rgb(x, y)) begin
        if (e_rgb == 0) begin fx = x; fo = {red, green, blue}; fe = exp_rgb(x, y); end
        e_rgb++;
      end
      if (video_on !== (x < H_VIS && y < V_VIS)) e_vo++;
      if (hsync !== !(x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SYNC)) e_hs++;
      if (vsync !== 1'b1) e_vs++;
    end
    check($sformatf("%s_rgb_errs(first x=%0d obs=%03h exp=%03h)", tag, fx, fo, fe), 32'(e_rgb), 32'd0);
    check($sformatf("%s_video_on_errs", tag), 32'(e_vo), 32'd0);
    check($sformatf("%s_hsync_errs", tag), 32'(e_hs), 32'd0);
    check($sformatf("%s_vsync_errs", tag), 32'(e_vs), 32'd0);
  endtask

  initial begin
    int guard, f1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'({red, green, blue}), 32'd0);
    check("rst_video_on", 32'(video_on), 32'd0);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    cyc = 0;
    step();
    check("first_px_video_on", 32'(video_on), 32'd1);
    check("first_px_hsync", 32'(hsync), 32'd1);

    // Horizontal sync timing
    guard = 0;
    while (hsync !== 1'b0 && guard < 2 * H_T) begin step(); guard++; end
    check("first_hsync_fall", 32'(cyc), 32'(H_VIS + H_FP + 1));
    f1 = cyc;
    guard = 0;
    while (hsync === 1'b0 && guard < 2 * H_T) begin step(); guard++; end
    check("hsync_width", 32'(guard), 32'(H_SYNC));
    guard = 0;
    while (hsync !== 1'b0 && guard < 2 * H_T) begin step(); guard++; end
    check("hsync_period", 32'(cyc - f1), 32'(H_T));

    // Vertical sync timing
    guard = 0;
    while (vsync !== 1'b0 && guard < 2 * FRAME) begin step(); guard++; end
    check("first_vsync_fall", 32'(cyc), 32'((V_VIS + V_FP) * H_T + 1));
    f1 = cyc;
    guard = 0;
    while (vsync === 1'b0 && guard < 2 * FRAME) begin step(); guard++; end
    check("vsync_width", 32'(guard), 32'(V_SYNC * H_T));
    guard = 0;
    while (vsync !== 1'b0 && guard < 2 * FRAME) begin step(); guard++; end
    check("vsync_period", 32'(cyc - f1), 32'(FRAME));

    // Empty battery, then 5 applied mid-frame must not tear
    scan_row("empty", ROW);
    pixel("empty_interior", 300, ROW + 1, 12'h000);
    pixel("nub", 405, ROW + 2, 12'hFFF);
    goto(0, 100);
    bat_ctl = 5'h05;
    scan_row("lvl5_same_frame", ROW);
    goto_tick();
    scan_row("lvl5", ROW);
    pixel("lvl5_outline", 241, ROW + 1, 12'hFFF);
    pixel("lvl5_x244", 244, ROW + 1, 12'hFF0);
    pixel("lvl5_x318", 318, ROW + 1, 12'hFF0);
    pixel("lvl5_x319", 319, ROW + 1, 12'h000);

    bat_ctl = 5'h0F;
    goto_tick();
    scan_row("lvl15", ROW);
    pixel("lvl15_x393", 393, ROW + 1, 12'h0F0);
    pixel("lvl15_x394", 394, ROW + 1, 12'h000);
    pixel("lvl15_x395", 395, ROW + 1, 12'h000);

    bat_ctl = 5'h01;
    goto_tick();
    scan_row("lvl1", ROW);
    pixel("lvl1_x258", 258, ROW + 1, 12'hF00);
    pixel("lvl1_x259", 259, ROW + 1, 12'h000);

    bat_ctl = 5'h00;
    goto_tick();
    scan_row("lvl0", ROW);

    // Charging blink: BF frames green, BF frames blue, repeating
    bat_ctl = 5'h18;
    goto_tick();
    for (int f = 0; f < 2 * BF + 1; f++) begin
      scan_row($sformatf("blink_f%0d", f), ROW);
      pixel($sformatf("blink_px_f%0d", f), 250, ROW + 1, ((f / BF) % 2 == 1) ? 12'h00F : 12'h0F0);
      goto_tick();
    end
    bat_ctl = 5'h08;
    goto_tick();
    scan_row("chg_off", ROW);
    pixel("chg_off_px", 250, ROW + 1, 12'h0F0);
    check("blink_ph_cleared", 32'(dut.blink_ph), 32'd0);

    // Asynchronous reset mid-frame
    goto(299, 100);
    check("pre_rst_video_on", 32'(video_on), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_video_on", 32'(video_on), 32'd0);
    check("async_rst_hsync", 32'(hsync), 32'd1);
    check("async_rst_vsync", 32'(vsync), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    m_lvl = 0; m_chg = 1'b0; m_n = 0;
    step();
    check("restart_video_on", 32'(video_on), 32'd1);
    check("restart_rgb", 32'({red, green, blue}), 32'd0);
    guard = 0;
    while (hsync !== 1'b0 && guard < 2 * H_T) begin step(); guard++; end
    check("restart_hsync_fall", 32'(cyc), 32'(H_VIS + H_FP + 1));
    scan_row("after_rst", ROW);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
